// File: rtl/rom_sample_streamer.sv
// Streams 16-bit samples from a synchronous-read ROM into a ready/valid sample
// stream, with single/looped playback, abort, and a small output FIFO.
module rom_sample_streamer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] num_samples,
    output logic [31:0]      rom_addr,
    input  logic [15:0]      rom_rd,
    output logic             s_valid,
    input  logic             s_ready,
    output logic [15:0]      s_data,
    output logic             s_last,
    output logic             busy,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ABORT} state_t;

    state_t           state, state_nxt;
    logic [31:0]      base_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] idx_q;
    logic             loop_q;
    logic             zdone_q;

    // Read issued last cycle; its data is on rom_rd this cycle
    logic             pend_p1;
    logic             last_p1;

    logic [16:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic launch, zero_start, abort_req, credit, idx_last;
    logic issue, push, pop, drained;

    assign launch     = (state == IDLE) && start && !stop && (num_samples != '0);
    assign zero_start = (state == IDLE) && start && !stop && (num_samples == '0);
    assign abort_req  = ((state == RUN) || (state == DRAIN)) && stop;
    assign credit     = (int'(count) + int'(pend_p1)) < DEPTH;
    assign idx_last   = (idx_q == (num_q - CNT_W'(1)));
    assign push       = pend_p1 && (state != ABORT);
    assign pop        = s_valid && s_ready;
    assign drained    = (count == '0) && !pend_p1;

    assign rom_addr = base_q + (32'(idx_q) << 2);
    assign s_valid  = (count != '0);
    assign s_data   = s_valid ? mem[rd_ptr][15:0] : 16'h0000;
    assign s_last   = s_valid ? mem[rd_ptr][16] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (launch) state_nxt = RUN;
            RUN: begin
                if (abort_req)                          state_nxt = ABORT;
                else if (issue && idx_last && !loop_q)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort_req)    state_nxt = ABORT;
                else if (drained) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        issue = (state == RUN) && !stop && credit;
        done  = zdone_q || ((state == DRAIN) && drained && !stop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            num_q   <= '0;
            loop_q  <= 1'b0;
            idx_q   <= '0;
            pend_p1 <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            pend_p1 <= issue;
            zdone_q <= zero_start;
            if (launch) begin
                base_q <= base_addr & 32'hFFFF_FFFC;
                num_q  <= num_samples;
                loop_q <= loop_en;
                idx_q  <= '0;
            end else if (issue) begin
                idx_q <= idx_last ? '0 : idx_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        last_p1 <= idx_last;
        if (push) mem[wr_ptr] <= {last_p1, rom_rd};
    end

    // FIFO pointers; an abort flushes everything including a same-cycle push
    always_ff @(posedge clk) begin
        if (rst || abort_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

endmodule
